// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } uart_state_e;

  function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1, one-cycle tick at DIV-1, synchronous clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a valid/ack output handshake.
//   state | meaning
//   IDLE  | line high, waiting for a start edge
//   START | checking the start bit at mid-bit
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | checking the stop bit
//   BRK   | stop bit was low; wait for the line to return high
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_data,
  output logic [7:0] dout,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_done,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  import uart_pkg::*;

  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);

  uart_state_e   state_q, state_d;
  logic          sync1_q, rx_s_q;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    b_q, b_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          done_q, ferr_q;
  logic          tick, tick_clr, complete, ferr_d, ack_take;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_data;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    b_d      = b_q;
    shreg_d  = shreg_q;
    tick_clr = 1'b0;
    complete = 1'b0;
    ferr_d   = 1'b0;
    if (tick && state_q != IDLE) s_d = s_q + SW'(1);
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d  = START;
        s_d      = '0;
        tick_clr = 1'b1;
      end
      START: if (tick && s_q == SW'(OVERSAMPLE / 2 - 1)) begin
        if (!rx_s_q) begin
          state_d = DATA;
          s_d     = '0;
          b_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (tick && s_q == SW'(OVERSAMPLE - 1)) begin
        shreg_d = {rx_s_q, shreg_q[7:1]};
        if (b_q == 3'd7) state_d = STOP;
        else             b_d     = b_q + 3'd1;
      end
      STOP: if (tick && s_q == SW'(OVERSAMPLE - 1)) begin
        // Leave at mid-stop-bit so an immediately following start bit is caught.
        if (rx_s_q) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          ferr_d   = 1'b1;
          state_d  = BRK;
        end
      end
      BRK: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_take  = rx_ack && valid_q;
    dout_d    = complete ? shreg_q : dout_q;
    valid_d   = complete | (valid_q & ~ack_take);
    overrun_d = (overrun_q | (complete & valid_q)) & ~ack_take;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      s_q       <= '0;
      b_q       <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      b_q       <= b_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      done_q    <= complete;
      ferr_q    <= ferr_d;
    end
  end

  assign dout      = dout_q;
  assign rx_valid  = valid_q;
  assign overrun   = overrun_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (54 clocks per tick, 864 per bit).
module tb_uart_rx;

  localparam int BIT       = 864;
  localparam int BIT_SHORT = 847;
  localparam int BIT_LONG  = 881;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_data = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] dout;
  logic       rx_valid, rx_done, frame_err, overrun, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  uart_rx dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .dout     (dout),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  // Must be called right after a negedge; leaves the line at the stop level.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int bitclk);
    rx_data   = 1'b0;
    start_cyc = cyc;
    repeat (bitclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_data = d[i];
      repeat (bitclk) @(negedge clk);
    end
    rx_data = stop_bit;
    repeat (bitclk) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx_data = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rx_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got done=%b ferr=%b expected 0 0", rx_done, frame_err);
    end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int lat;
    send_byte(8'hA5, 1'b1, BIT);
    repeat (2) @(negedge clk);
    lat = done_cyc - start_cyc;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++; if (lat < 8209 || lat > 8211) begin errors++; $display("FAIL basic_latency: got %0d expected 8209..8211", lat); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL basic_dout: got %h expected a5", dout); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL basic_ferr: got %0d expected 0", ferr_cnt); end
    checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL basic_idle: got busy=%b overrun=%b expected 0 0", busy, overrun);
    end
  endtask

  task automatic test_glitch();
    int d0;
    d0 = done_cnt;
    rx_data = 1'b0;
    repeat (162) @(negedge clk);
    rx_data = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
    repeat (432) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL glitch_done: got %0d expected %0d", done_cnt, d0); end
    checks++; if (dout !== 8'hA5 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL glitch_hold: got dout=%h valid=%b expected a5 1", dout, rx_valid);
    end
  endtask

  task automatic test_frame_err();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0, BIT);
    repeat (19 * BIT) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy: got %b expected 1", busy); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL ferr_done: got %0d expected %0d", done_cnt, d0); end
    checks++; if (dout !== 8'hA5 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ferr_hold: got dout=%h valid=%b expected a5 1", dout, rx_valid);
    end
    rx_data = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_release: got busy=%b expected 0", busy); end
    repeat (BIT) @(negedge clk);
    checks++; if (ferr_cnt - f0 !== 1 || done_cnt !== d0) begin
      errors++; $display("FAIL brk_quiet: got ferr=%0d done=%0d expected 1 %0d", ferr_cnt - f0, done_cnt, d0);
    end
  endtask

  // rx_valid is still set from 0xA5, so the first ack lands on the completion edge.
  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    fork
      begin
        send_byte(8'h00, 1'b1, BIT);
        send_byte(8'hFF, 1'b1, BIT);
      end
      begin
        int s0;
        bit got;
        @(negedge clk);
        s0 = start_cyc;
        while (cyc < s0 + 8210) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        checks++; if (rx_done !== 1'b1) begin errors++; $display("FAIL b2b_done0: got %b expected 1", rx_done); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL b2b_dout0: got %h expected 00", dout); end
        checks++; if (rx_valid !== 1'b1 || overrun !== 1'b0) begin
          errors++; $display("FAIL b2b_same_cycle_ack: got valid=%b overrun=%b expected 1 0", rx_valid, overrun);
        end
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack0: got valid=%b expected 0", rx_valid); end
        got = 1'b0;
        for (int c = 0; c < 12000 && !got; c++) begin
          @(negedge clk);
          if (rx_done === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL b2b_timeout: got no rx_done expected one"); end
        checks++; if (dout !== 8'hFF || overrun !== 1'b0) begin
          errors++; $display("FAIL b2b_byte1: got dout=%h overrun=%b expected ff 0", dout, overrun);
        end
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack1: got valid=%b expected 0", rx_valid); end
      end
    join
    repeat (2) @(negedge clk);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", done_cnt - d0); end
  endtask

  task automatic test_overrun();
    int d0;
    d0 = done_cnt;
    send_byte(8'h11, 1'b1, BIT);
    send_byte(8'h22, 1'b1, BIT_SHORT);
    repeat (2) @(negedge clk);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL ovr_count: got %0d expected 2", done_cnt - d0); end
    checks++; if (dout !== 8'h22) begin errors++; $display("FAIL ovr_dout: got %h expected 22", dout); end
    checks++; if (overrun !== 1'b1 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got overrun=%b valid=%b expected 1 1", overrun, rx_valid);
    end
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    checks++; if (overrun !== 1'b0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_ack: got overrun=%b valid=%b expected 0 0", overrun, rx_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, f0;
    logic [7:0] v;
    v = 8'h5A;
    d0 = done_cnt;
    f0 = ferr_cnt;
    rx_data = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_data = v[i];
      repeat (BIT) @(negedge clk);
    end
    rx_data = v[4];
    repeat (BIT / 2) @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || dout !== 8'h00) begin
      errors++; $display("FAIL midrst_state: got busy=%b dout=%h expected 0 00", busy, dout);
    end
    rx_data = 1'b1;
    rstn = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++; if (done_cnt !== d0 || ferr_cnt !== f0) begin
      errors++; $display("FAIL midrst_pulses: got done=%0d ferr=%0d expected %0d %0d", done_cnt, ferr_cnt, d0, f0);
    end
    send_byte(8'h81, 1'b1, BIT_LONG);
    repeat (2) @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (dout !== 8'h81 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_byte: got dout=%h valid=%b expected 81 1", dout, rx_valid);
    end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL midrst_ferr: got %0d expected %0d", ferr_cnt, f0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion within 150000 cycles expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
